pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Program-counter controller for the 8-bit core. Sequences instruction fetch,
//  steps the PC, and applies jump requests from decode after validating the
//  label code against the fixed label map. Halts on the exit label, faults on
//  unknown labels. Sits between decode and instruction memory; sole PC owner.
// PARAMETERS
//  PC_W      8    PC and label width (bits)
//  PC_STEP   4    byte increment per sequential instruction
//  CNT_W     16   width of retired-instruction counter
// PORTS
//  clk          in   1      rising-edge clock, single domain
//  rst_n        in   1      reset, synchronous, active-low
//  start        in   1      one-cycle pulse; leaves IDLE and begins fetching at MAIN
//  fetch_req    out  1      instruction-memory read request, address = pc
//  fetch_ack    in   1      memory accepts request / instruction valid this cycle
//  pc           out  PC_W   current program counter
//  instr_done   in   1      decode finished current instruction (one-cycle pulse)
//  jmp_valid    in   1      qualifies instr_done: instruction is a taken jump/branch
//  jmp_etq      in   PC_W   label code of jump target, sampled with instr_done
//  halted       out  1      sticky: exit reached
//  fault        out  1      sticky: illegal label or PC overflow
//  fault_etq    out  PC_W   offending label (or PC) captured on fault
//  retired      out  CNT_W  count of completed instructions, saturating
// BEHAVIOUR
//  Label map (code -> PC, identity): MAIN 0x04, LOOP 0x10, SUMA 0x38,
//   SUMAAUX 0x50, DONE 0x70, EXIT 0x80. Any other jmp_etq is illegal.
//  Reset (rst_n=0 at edge): state=IDLE, pc=0x04, fetch_req=0, halted=0,
//   fault=0, fault_etq=0, retired=0. Reset wins over all other inputs.
//  States: IDLE, FETCH, EXEC, HALT, FAULT.
//  IDLE : fetch_req=0; start=1 -> FETCH next cycle. Other inputs ignored.
//  FETCH: fetch_req=1 (registered, asserted the cycle FETCH is entered),
//   pc held stable. fetch_ack=1 -> EXEC, fetch_req=0 next cycle. Unbounded wait.
//   If pc==EXIT on entry to FETCH: go to HALT instead, no request issued.
//  EXEC : waits for instr_done. On instr_done:
//   jmp_valid=0: pc<=pc+PC_STEP; if pc+PC_STEP overflows PC_W -> FAULT,
//    fault_etq<=pc, pc unchanged.
//   jmp_valid=1, legal label: pc<=mapped target; EXIT target is legal
//    (halt happens on next FETCH entry).
//   jmp_valid=1, illegal: -> FAULT, fault_etq<=jmp_etq, pc unchanged.
//   Legal completion: retired++ (saturate at all-ones), state -> FETCH.
//   Faulting instruction is not counted.
//  instr_done or fetch_ack outside its state: ignored, no side effects.
//  HALT : halted=1, fetch_req=0; terminal until reset (start ignored).
//  FAULT: fault=1, fetch_req=0; terminal until reset.
//  Latency: instr_done -> new pc visible 1 cycle later, fetch_req same cycle
//   as new pc. Min per instruction: 2 cycles (FETCH ack same cycle + EXEC done).
//  Reset mid-fetch: request dropped next cycle; memory must tolerate abort.
// STRUCTURE
//  Shared package cpu_pkg: label constants (LBL_MAIN..LBL_EXIT), PC_STEP,
//   pc_state_e enum {IDLE,FETCH,EXEC,HALT,FAULT}.
//  One sub-module: label_resolve (combinational: jmp_etq -> target, legal).
//  Remainder: single FSM + PC/counter registers in this module.
// TESTING
//  Reset, no start for 10 cycles -> pc=0x04, fetch_req=0, retired=0.
//  start; ack after 3 wait cycles; instr_done jmp_valid=0 -> pc=0x08, retired=1.
//  From pc=0x08, instr_done jmp_valid=1 jmp_etq=0x10 -> pc=0x10, fetch_req=1.
//  jmp_etq=0x20 -> fault=1, fault_etq=0x20, pc stays, retired unchanged.
//  jmp_etq=0x80 -> one retire, then halted=1, fetch_req never asserted at 0x80.
//  rst_n=0 during FETCH wait -> next cycle IDLE, pc=0x04, all flags cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared constants and types for the 8-bit core's program-counter controller:
// fixed label map, sequential step size and the sequencer state encoding.
package cpu_pkg;

  localparam int PC_W  = 8;
  localparam int CNT_W = 16;

  localparam logic [PC_W-1:0] PC_STEP     = 8'h04;

  localparam logic [PC_W-1:0] LBL_MAIN    = 8'h04;
  localparam logic [PC_W-1:0] LBL_LOOP    = 8'h10;
  localparam logic [PC_W-1:0] LBL_SUMA    = 8'h38;
  localparam logic [PC_W-1:0] LBL_SUMAAUX = 8'h50;
  localparam logic [PC_W-1:0] LBL_DONE    = 8'h70;
  localparam logic [PC_W-1:0] LBL_EXIT    = 8'h80;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    HALT  = 3'd3,
    FAULT = 3'd4
  } pc_state_e;

endpackage

// File: rtl/label_resolve.sv
// Combinational label decoder: maps a jump label code to its target PC and
// flags whether the code belongs to the fixed label map.
module label_resolve
  import cpu_pkg::*;
(
  input  logic [PC_W-1:0] etq,
  output logic [PC_W-1:0] target,
  output logic            legal
);

  // Map is identity, so a legal code is its own target address.
  always_comb begin
    target = etq;
    case (etq)
      LBL_MAIN, LBL_LOOP, LBL_SUMA, LBL_SUMAAUX, LBL_DONE, LBL_EXIT: legal = 1'b1;
      default:                                                      legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: sequences fetch/execute, steps or redirects the
// PC, halts at the exit label and latches a sticky fault on bad targets.
module pc_sequencer
  import cpu_pkg::*;
#(
  parameter int              PC_W    = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0] PC_STEP = cpu_pkg::PC_STEP,
  parameter int              CNT_W   = cpu_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             fetch_req,
  input  logic             fetch_ack,
  output logic [PC_W-1:0]  pc,
  input  logic             instr_done,
  input  logic             jmp_valid,
  input  logic [PC_W-1:0]  jmp_etq,
  output logic             halted,
  output logic             fault,
  output logic [PC_W-1:0]  fault_etq,
  output logic [CNT_W-1:0] retired
);

  pc_state_e        state_r, state_next_s;
  logic [PC_W-1:0]  pc_r, pc_next_s;
  logic [PC_W-1:0]  fault_etq_r, fault_etq_next_s;
  logic [CNT_W-1:0] retired_r, retired_next_s;
  logic             fetch_req_r, halted_r, fault_r;
  logic             fetch_req_next_s, halted_next_s, fault_next_s;

  logic [PC_W:0]    pc_step_sum_s;
  logic [PC_W-1:0]  jmp_target_s;
  logic             jmp_legal_s;
  logic [PC_W-1:0]  pc_cand_s;
  logic [PC_W-1:0]  bad_etq_s;
  logic             bad_s;

  label_resolve u_label_resolve (
    .etq    (jmp_etq),
    .target (jmp_target_s),
    .legal  (jmp_legal_s)
  );

  // Extra carry bit exposes a step past the top of the address space.
  assign pc_step_sum_s = {1'b0, pc_r} + {1'b0, PC_STEP};

  // Candidate next PC for the completing instruction and whether it must fault.
  always_comb begin
    if (jmp_valid) begin
      pc_cand_s = jmp_target_s;
      bad_s     = ~jmp_legal_s;
      bad_etq_s = jmp_etq;
    end else begin
      pc_cand_s = pc_step_sum_s[PC_W-1:0];
      bad_s     = pc_step_sum_s[PC_W];
      bad_etq_s = pc_r;
    end
  end

  // Next-state and datapath update; landing on EXIT goes straight to HALT
  // so no request is ever issued for that address.
  always_comb begin
    state_next_s     = state_r;
    pc_next_s        = pc_r;
    fault_etq_next_s = fault_etq_r;
    retired_next_s   = retired_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (pc_r == LBL_EXIT) ? HALT : FETCH;
        end else begin
          state_next_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_ack) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = FETCH;
        end
      end
      EXEC: begin
        if (!instr_done) begin
          state_next_s = EXEC;
        end else if (bad_s) begin
          state_next_s     = FAULT;
          fault_etq_next_s = bad_etq_s;
        end else begin
          pc_next_s      = pc_cand_s;
          retired_next_s = (&retired_r) ? retired_r
                                        : retired_r + {{(CNT_W-1){1'b0}}, 1'b1};
          state_next_s   = (pc_cand_s == LBL_EXIT) ? HALT : FETCH;
        end
      end
      HALT:    state_next_s = HALT;
      FAULT:   state_next_s = FAULT;
      default: state_next_s = FAULT;
    endcase
  end

  // Registered outputs are derived from the state being entered.
  always_comb begin
    fetch_req_next_s = 1'b0;
    halted_next_s    = 1'b0;
    fault_next_s     = 1'b0;
    case (state_next_s)
      FETCH:   fetch_req_next_s = 1'b1;
      HALT:    halted_next_s    = 1'b1;
      FAULT:   fault_next_s     = 1'b1;
      default: fetch_req_next_s = 1'b0;
    endcase
  end

  // State, PC, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      pc_r        <= LBL_MAIN;
      fault_etq_r <= {PC_W{1'b0}};
      retired_r   <= {CNT_W{1'b0}};
      fetch_req_r <= 1'b0;
      halted_r    <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      pc_r        <= pc_next_s;
      fault_etq_r <= fault_etq_next_s;
      retired_r   <= retired_next_s;
      fetch_req_r <= fetch_req_next_s;
      halted_r    <= halted_next_s;
      fault_r     <= fault_next_s;
    end
  end

  assign fetch_req = fetch_req_r;
  assign pc        = pc_r;
  assign halted    = halted_r;
  assign fault     = fault_r;
  assign fault_etq = fault_etq_r;
  assign retired   = retired_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected fetch/halt/fault
// events from a label-map model; an edge-driven monitor pops and compares.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        fetch_ack = 1'b0;
  logic        instr_done = 1'b0;
  logic        jmp_valid = 1'b0;
  logic [7:0]  jmp_etq = 8'h00;
  logic        fetch_req, halted, fault;
  logic [7:0]  pc, fault_etq;
  logic [15:0] retired;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .fetch_req  (fetch_req),
    .fetch_ack  (fetch_ack),
    .pc         (pc),
    .instr_done (instr_done),
    .jmp_valid  (jmp_valid),
    .jmp_etq    (jmp_etq),
    .halted     (halted),
    .fault      (fault),
    .fault_etq  (fault_etq),
    .retired    (retired)
  );

  typedef enum int {EV_FETCH = 0, EV_HALT = 1, EV_FAULT = 2} ev_e;
  typedef struct { ev_e kind; int pc; int ret; int etq; } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_pc, m_ret;
  bit   m_stop;
  int   label_map[int];
  int   legal_list[5] = '{32'h04, 32'h10, 32'h38, 32'h50, 32'h70};

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input ev_e k, input int p, input int r, input int e);
    exp_t x;
    x.kind = k; x.pc = p; x.ret = r; x.etq = e;
    exp_q.push_back(x);
  endtask

  // Reference: what one completed instruction does, in terms of the label map.
  task automatic model_step(input bit jv, input int etq);
    int np;
    bit bad;
    int bad_etq;
    np = m_pc;
    if (jv) begin
      bad = !label_map.exists(etq);
      bad_etq = etq;
      if (!bad) np = label_map[etq];
    end else begin
      np = m_pc + 4;
      bad = (np > 255);
      bad_etq = m_pc;
    end
    if (bad) begin
      push_exp(EV_FAULT, m_pc, m_ret, bad_etq);
      m_stop = 1'b1;
    end else begin
      m_ret = (m_ret == 65535) ? 65535 : m_ret + 1;
      m_pc  = np;
      if (np == 32'h80) begin
        push_exp(EV_HALT, m_pc, m_ret, 0);
        m_stop = 1'b1;
      end else begin
        push_exp(EV_FETCH, m_pc, m_ret, 0);
      end
    end
  endtask

  // Monitor: every rising fetch_req / halted / fault is one DUT event.
  initial begin : monitor
    logic p_fr, p_h, p_f;
    ev_e  k;
    exp_t e;
    p_fr = 1'b0; p_h = 1'b0; p_f = 1'b0;
    forever begin
      @(negedge clk);
      if ((fault && !p_f) || (halted && !p_h) || (fetch_req && !p_fr)) begin
        k = (fault && !p_f) ? EV_FAULT : ((halted && !p_h) ? EV_HALT : EV_FETCH);
        if (exp_q.size() == 0) begin
          chk("unexpected_event", int'(k), -1);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", int'(k), int'(e.kind));
          chk("event_pc", int'(pc), e.pc);
          chk("event_retired", int'(retired), e.ret);
          if (e.kind == EV_FAULT) chk("event_fault_etq", int'(fault_etq), e.etq);
          if (e.kind != EV_FETCH) chk("no_req_when_stopped", int'(fetch_req), 0);
        end
      end
      p_fr = fetch_req; p_h = halted; p_f = fault;
    end
  end

  task automatic do_reset(input int cycles);
    @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    rst_n = 1'b0;
    start = 1'($urandom); instr_done = 1'($urandom); fetch_ack = 1'($urandom);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1; start = 1'b0; instr_done = 1'b0; fetch_ack = 1'b0;
    chk("rst_pc", int'(pc), 32'h04);
    chk("rst_fetch_req", int'(fetch_req), 0);
    chk("rst_halted", int'(halted), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_fault_etq", int'(fault_etq), 0);
    chk("rst_retired", int'(retired), 0);
  endtask

  task automatic do_start();
    m_pc = 32'h04; m_ret = 0; m_stop = 1'b0;
    push_exp(EV_FETCH, m_pc, 0, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_instr(input bit jv, input logic [7:0] etq, input int ack_wait, input int done_wait);
    int guard;
    guard = 0;
    while (!fetch_req && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("fetch_req_seen", int'(fetch_req), 1);
    if (!fetch_req) begin
      m_stop = 1'b1;
      return;
    end
    for (int i = 0; i < ack_wait; i++) begin
      instr_done = ($urandom_range(0, 3) == 0);
      jmp_valid  = 1'($urandom);
      jmp_etq    = 8'($urandom);
      @(posedge clk); #1;
      chk("pc_stable_in_fetch", int'(pc), m_pc);
      chk("req_held", int'(fetch_req), 1);
    end
    instr_done = 1'b0;
    fetch_ack  = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    for (int i = 0; i < done_wait; i++) begin
      fetch_ack = ($urandom_range(0, 2) == 0);
      @(posedge clk); #1;
      chk("pc_stable_in_exec", int'(pc), m_pc);
    end
    fetch_ack = 1'b0;
    model_step(jv, int'(etq));
    instr_done = 1'b1; jmp_valid = jv; jmp_etq = etq;
    @(posedge clk); #1;
    instr_done = 1'b0; jmp_valid = 1'b0; jmp_etq = 8'h00;
  endtask

  // Terminal states must ignore everything, including start.
  task automatic check_terminal(input bit exp_halt, input int exp_pc);
    repeat (4) begin
      start = 1'b1; fetch_ack = 1'b1; instr_done = 1'b1;
      jmp_valid = 1'($urandom); jmp_etq = 8'($urandom);
      @(posedge clk); #1;
      chk("term_no_req", int'(fetch_req), 0);
    end
    start = 1'b0; fetch_ack = 1'b0; instr_done = 1'b0; jmp_valid = 1'b0; jmp_etq = 8'h00;
    chk("term_halted", int'(halted), int'(exp_halt));
    chk("term_fault", int'(fault), int'(!exp_halt));
    chk("term_pc", int'(pc), exp_pc);
    chk("term_retired", int'(retired), m_ret);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int r;
    logic [7:0] etq;
    label_map[32'h04] = 32'h04; label_map[32'h10] = 32'h10; label_map[32'h38] = 32'h38;
    label_map[32'h50] = 32'h50; label_map[32'h70] = 32'h70; label_map[32'h80] = 32'h80;
    m_pc = 32'h04; m_ret = 0; m_stop = 1'b0;

    // Idle for 10 cycles with noise on the other inputs.
    do_reset(2);
    for (int i = 0; i < 10; i++) begin
      fetch_ack = 1'($urandom); instr_done = 1'($urandom); jmp_valid = 1'($urandom);
      @(posedge clk); #1;
      chk("idle_no_req", int'(fetch_req), 0);
    end
    fetch_ack = 1'b0; instr_done = 1'b0; jmp_valid = 1'b0;
    chk("idle_pc", int'(pc), 32'h04);
    chk("idle_retired", int'(retired), 0);

    // Sequential step, legal jump, then an illegal label.
    do_start();
    do_instr(1'b0, 8'h00, 3, 0);
    chk("step_pc", int'(pc), 32'h08);
    chk("step_retired", int'(retired), 1);
    do_instr(1'b1, 8'h10, 0, 1);
    chk("jump_pc", int'(pc), 32'h10);
    chk("jump_req", int'(fetch_req), 1);
    do_instr(1'b1, 8'h20, 1, 0);
    chk("fault_etq", int'(fault_etq), 32'h20);
    check_terminal(1'b0, 32'h10);

    // Jump straight to EXIT.
    do_reset(1);
    do_start();
    do_instr(1'b1, 8'h80, 0, 0);
    check_terminal(1'b1, 32'h80);

    // Walk sequentially from DONE into EXIT.
    do_reset(1);
    do_start();
    do_instr(1'b1, 8'h70, 1, 1);
    for (int i = 0; i < 4; i++) do_instr(1'b0, 8'h00, $urandom_range(0, 2), $urandom_range(0, 2));
    check_terminal(1'b1, 32'h80);

    // Reset while waiting for fetch_ack.
    do_reset(1);
    do_start();
    repeat (2) begin @(posedge clk); #1; end
    chk("pre_abort_req", int'(fetch_req), 1);
    do_reset(1);
    repeat (3) begin
      @(posedge clk); #1;
      chk("abort_idle", int'(fetch_req), 0);
    end

    // Randomised programs.
    for (int ep = 0; ep < 15; ep++) begin
      do_reset($urandom_range(1, 2));
      do_start();
      for (int n = 0; n < 30 && !m_stop; n++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      etq = 8'h80;
        else if (r == 1) etq = 8'($urandom);
        else             etq = 8'(legal_list[$urandom_range(0, 4)]);
        do_instr(($urandom_range(0, 9) < 4), etq, $urandom_range(0, 3), $urandom_range(0, 2));
      end
      if (m_stop) check_terminal(fault ? 1'b0 : 1'b1, m_pc);
    end

    @(negedge clk);
    @(negedge clk);
    chk("final_queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
